// File: rtl/spike_event_queue.sv
// spike_event_queue
// Wishbone-fed axon-event FIFO in front of neuron_core. The host pushes axon
// indices through a 16-byte Wishbone window; the queue drains them one per
// valid/ready handshake. On request, a single-cycle timestep tick is issued
// once every queued event has been consumed.
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   wbs_*               Wishbone slave (cyc/stb/we/sel/adr/dat_i in, dat_o/ack out)
//   axon_valid_o        queue head valid
//   axon_idx_o          queue head axon index (0 while empty)
//   axon_ready_i        core accepts the head this cycle
//   tick_o              one-cycle timestep pulse
//
// Register map (adr[3:2]):
//   0 PUSH   W  enqueue dat[AXON_W-1:0]; drops and sets ovf when full w/o pop
//   1 STATUS R  [5:0] count, 8 empty, 9 full, 10 ovf, 11 tick_busy; W1C bit10
//   2 CTRL   W  bit0 tick request, bit1 flush
//   3 reserved
module spike_event_queue #(
    parameter int          AXON_W    = 8,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              axon_valid_o,
    output logic [AXON_W-1:0] axon_idx_o,
    input  logic              axon_ready_i,
    output logic              tick_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        TICK  = 2'd2
    } tick_state_t;

    logic [AXON_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              ovf;
    tick_state_t       state;

    logic        hit;
    logic [1:0]  reg_sel;
    logic        push_req;
    logic        status_wr;
    logic        ctrl_wr;
    logic        flush;
    logic        tick_req;
    logic        full;
    logic        pop;
    logic        push_ok;
    logic        tick_busy;
    logic [31:0] rd_data;

    // Byte selects, the byte offset and most write-data bits carry no meaning
    // here; folding them keeps the intent explicit.
    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

    // A strobe seen while ack is already high is the tail of the previous
    // access, so it is neither acked nor allowed to have side effects.
    assign hit = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o
               & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);

    assign reg_sel   = wbs_adr_i[3:2];
    assign push_req  = hit & wbs_we_i & (reg_sel == 2'd0);
    assign status_wr = hit & wbs_we_i & (reg_sel == 2'd1);
    assign ctrl_wr   = hit & wbs_we_i & (reg_sel == 2'd2);
    assign flush     = ctrl_wr & wbs_dat_i[1];
    assign tick_req  = ctrl_wr & wbs_dat_i[0];

    assign full         = (count == CNT_W'(DEPTH));
    assign axon_valid_o = (count != '0);
    assign pop          = axon_valid_o & axon_ready_i;
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    assign push_ok      = push_req & (~full | pop);
    assign tick_busy    = (state != IDLE);

    assign axon_idx_o = axon_valid_o ? mem[rd_ptr] : '0;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rd_data = '0;
        if (reg_sel == 2'd1) begin
            rd_data = {20'd0, tick_busy, ovf, full, (count == '0), 2'b00, 6'(count)};
        end
    end

    // NOTE: the entry storage has no reset; the head output is gated by
    // valid, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= wbs_dat_i[AXON_W-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Flush wins over any pop on the same edge.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (push_req && full && !pop) begin
            ovf <= 1'b1;
        end else if (status_wr && wbs_dat_i[10]) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= hit;
            wbs_dat_o <= (hit && !wbs_we_i) ? rd_data : '0;
        end
    end

    // Tick sequencer: DRAIN waits for an empty queue, TICK lasts one cycle.
    // Requests outside IDLE are dropped rather than queued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            tick_o <= 1'b0;
        end else begin
            tick_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (count == '0) begin
                        state  <= TICK;
                        tick_o <= 1'b1;
                    end
                end
                TICK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_event_queue.sv
// Self-checking bench for spike_event_queue: a queue-based reference model
// checked against the DUT every cycle, directed scenarios with hand-computed
// expectations, and a randomized Wishbone/ready phase.
module tb_spike_event_queue;

    localparam int          AXON_W = 8;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] BASE   = 32'h3000_1000;
    localparam logic [31:0] A_PUSH = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cyc = 1'b0;
    logic              stb = 1'b0;
    logic              we  = 1'b0;
    logic [3:0]        sel = 4'hF;
    logic [31:0]       adr = '0;
    logic [31:0]       dat_i = '0;
    logic [31:0]       wbs_dat_o;
    logic              wbs_ack_o;
    logic              axon_valid_o;
    logic [AXON_W-1:0] axon_idx_o;
    logic              ready = 1'b0;
    logic              tick_o;

    spike_event_queue #(.AXON_W(AXON_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (dat_i),
        .wbs_dat_o    (wbs_dat_o),
        .wbs_ack_o    (wbs_ack_o),
        .axon_valid_o (axon_valid_o),
        .axon_idx_o   (axon_idx_o),
        .axon_ready_i (ready),
        .tick_o       (tick_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mq[$];
    bit          m_ovf;
    int          m_phase;   // 0 idle, 1 waiting for empty queue, 2 tick cycle
    bit          m_ack;
    bit          m_tick;
    logic [31:0] m_dat;

    always @(posedge clk or negedge rst) begin
        bit         take, pop, full, wr;
        int         sz;
        logic [1:0] r;
        if (!rst) begin
            mq.delete();
            m_ovf = 0; m_phase = 0; m_ack = 0; m_tick = 0; m_dat = '0;
        end else begin
            sz   = mq.size();
            full = (sz == DEPTH);
            take = cyc && stb && !m_ack && (adr[31:4] == BASE[31:4]);
            wr   = take && we;
            r    = adr[3:2];
            pop  = (sz > 0) && ready;

            m_dat = '0;
            if (take && !we && r == 2'd1)
                m_dat = 32'(sz) + ((sz == 0) ? 32'h100 : 0) + (full ? 32'h200 : 0)
                      + (m_ovf ? 32'h400 : 0) + ((m_phase != 0) ? 32'h800 : 0);
            m_ack = take;

            case (m_phase)
                0: if (wr && r == 2'd2 && dat_i[0]) m_phase = 1;
                1: if (sz == 0) m_phase = 2;
                default: m_phase = 0;
            endcase
            m_tick = (m_phase == 2);

            if (wr && r == 2'd2 && dat_i[1]) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (wr && r == 2'd0) begin
                    if (!full || pop) mq.push_back(dat_i[7:0]);
                    else              m_ovf = 1;
                end
            end
            if (wr && r == 2'd1 && dat_i[10]) m_ovf = 0;
        end
    end

    // ---------------- per-cycle compare and observation ----------------
    logic [7:0] popped[$];
    int cyc_n       = 0;
    int tick_cnt    = 0;
    int tick_at     = -1;
    int last_pop_at = -1;

    always @(negedge clk) begin
        cyc_n++;
        if (rst) begin
            check("ack",   32'(wbs_ack_o),    32'(m_ack));
            check("rdata", wbs_dat_o,         m_dat);
            check("valid", 32'(axon_valid_o), 32'(mq.size() != 0));
            check("idx",   32'(axon_idx_o),   (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
            check("tick",  32'(tick_o),       32'(m_tick));
            if (tick_o) begin
                tick_cnt++;
                tick_at = cyc_n;
            end
            if (axon_valid_o && ready) begin
                popped.push_back(axon_idx_o);
                last_pop_at = cyc_n;
            end
        end
    end

    // ---------------- Wishbone helpers ----------------
    task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                            output logic [31:0] rdata, output bit acked);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = a; dat_i = d;
        acked = 0; rdata = '0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin
                acked = 1;
                rdata = wbs_dat_o;
            end
        end
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        bit ok;
        wb_cycle(a, 1'b1, d, rd, ok);
        check("write_ack", 32'(ok), 32'h1);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        bit ok;
        wb_cycle(a, 1'b0, '0, d, ok);
        check("read_ack", 32'(ok), 32'h1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        bit          ok;
        int          n30;
        int          waited;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(axon_valid_o), 32'h0);
        check("rst_tick",  32'(tick_o),       32'h0);
        check("rst_ack",   32'(wbs_ack_o),    32'h0);
        @(negedge clk); rst = 1;

        wb_read(A_STAT, rd);
        check("status_after_reset", rd, 32'h100);

        // Reset mid-transfer and mid-drain.
        wb_write(A_PUSH, 32'h3);
        wb_write(A_PUSH, 32'h4);
        wb_write(A_CTRL, 32'h1);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = A_STAT;
        @(posedge clk); #2;
        rst = 0;
        #1;
        check("mid_rst_ack",   32'(wbs_ack_o),    32'h0);
        check("mid_rst_dat",   wbs_dat_o,         32'h0);
        check("mid_rst_valid", 32'(axon_valid_o), 32'h0);
        check("mid_rst_idx",   32'(axon_idx_o),   32'h0);
        check("mid_rst_tick",  32'(tick_o),       32'h0);
        cyc = 0; stb = 0;
        tick_cnt = 0;
        @(negedge clk); @(negedge clk); rst = 1;
        idle(10);
        check("abandoned_tick", 32'(tick_cnt), 32'h0);
        wb_read(A_STAT, rd);
        check("status_after_mid_reset", rd, 32'h100);

        // Ordered drain.
        ready = 0;
        wb_write(A_PUSH, 32'h05);
        wb_write(A_PUSH, 32'h11);
        wb_write(A_PUSH, 32'hFF);
        wb_read(A_STAT, rd);
        check("status_count3", rd, 32'h003);
        check("head_05", 32'(axon_idx_o), 32'h05);
        popped.delete();
        ready = 1;
        idle(5);
        ready = 0;
        check("drain_n", 32'(popped.size()), 32'h3);
        if (popped.size() == 3) begin
            check("drain_0", 32'(popped[0]), 32'h05);
            check("drain_1", 32'(popped[1]), 32'h11);
            check("drain_2", 32'(popped[2]), 32'hFF);
        end
        check("drain_valid_low", 32'(axon_valid_o), 32'h0);

        // Overflow: 17 pushes, the 17th (0x30) is dropped.
        for (int i = 0; i < 17; i++) wb_write(A_PUSH, 32'h20 + 32'(i));
        wb_read(A_STAT, rd);
        check("status_ovf", rd, 32'h610);
        wb_write(A_STAT, 32'h400);
        wb_read(A_STAT, rd);
        check("status_ovf_clr", rd, 32'h210);

        // Full with simultaneous pop.
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = A_PUSH; dat_i = 32'hAA; ready = 1;
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0; ready = 0;
        check("full_pop_ack", 32'(wbs_ack_o), 32'h1);
        wb_read(A_STAT, rd);
        check("status_full_pop", rd, 32'h210);
        popped.delete();
        ready = 1;
        idle(20);
        ready = 0;
        check("full_drain_n", 32'(popped.size()), 32'd16);
        if (popped.size() == 16) begin
            check("full_first", 32'(popped[0]),  32'h21);
            check("full_last",  32'(popped[15]), 32'hAA);
        end
        n30 = 0;
        foreach (popped[i]) if (popped[i] == 8'h30) n30++;
        check("dropped_never_out", 32'(n30), 32'h0);

        // Tick ordering with a redundant request during DRAIN.
        for (int i = 0; i < 4; i++) wb_write(A_PUSH, 32'h40 + 32'(i));
        tick_cnt = 0;
        wb_write(A_CTRL, 32'h1);
        idle(10);
        wb_write(A_CTRL, 32'h1);
        wb_read(A_STAT, rd);
        check("status_busy", rd, 32'h804);
        ready = 1;
        waited = 0;
        while (tick_cnt == 0 && waited < 40) begin
            idle(1);
            waited++;
        end
        idle(6);
        ready = 0;
        check("tick_once", 32'(tick_cnt), 32'h1);
        // Last handshake cycle, one empty DRAIN cycle, then the TICK cycle.
        check("tick_after_last_pop", 32'(tick_at - last_pop_at), 32'h2);
        wb_read(A_STAT, rd);
        check("status_idle_after_tick", rd, 32'h100);

        // Flush with 5 entries queued.
        for (int i = 0; i < 5; i++) wb_write(A_PUSH, 32'h60 + 32'(i));
        wb_write(A_CTRL, 32'h2);
        check("flush_valid_low", 32'(axon_valid_o), 32'h0);
        wb_read(A_STAT, rd);
        check("status_flushed", rd, 32'h100);

        // Address decode: accesses outside the window are ignored.
        wb_write(A_PUSH, 32'h77);
        wb_cycle(BASE + 32'h20, 1'b1, 32'h55, rd, ok);
        check("miss_push_noack", 32'(ok), 32'h0);
        wb_cycle(BASE + 32'h28, 1'b1, 32'h3, rd, ok);
        check("miss_ctrl_noack", 32'(ok), 32'h0);
        wb_read(A_STAT, rd);
        check("status_after_miss", rd, 32'h001);
        check("head_after_miss", 32'(axon_idx_o), 32'h77);
        ready = 1;
        idle(3);

        // Randomized phase: the per-cycle compare carries the checking.
        for (int c = 0; c < 600; c++) begin
            logic [1:0] r;
            @(posedge clk); #1;
            ready = (c < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            cyc   = ($urandom_range(0, 3) != 0);
            stb   = ($urandom_range(0, 3) != 0);
            we    = ($urandom_range(0, 3) != 0);
            r     = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
            adr   = BASE + {28'd0, r, 2'b00} + (($urandom_range(0, 9) == 0) ? 32'h20 : 32'h0);
            case (r)
                2'd2:    dat_i = {30'd0, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1))};
                default: dat_i = $urandom;
            endcase
        end
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0; ready = 1;
        idle(25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
